// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Contents:
//   GROUP_W     - width of one CLA group (4 bits)
//   MAX_GROUPS  - maximum number of groups per stage (64-bit operands / 4)
//   nstage_f    - number of carry-resolution stages for a WIDTH/STAGE_GROUPS pair
//   params_ok   - legality test for WIDTH/STAGE_GROUPS, used by the top at elaboration
//   la_carry    - stage-level lookahead carry into group j from group P/G terms
package cla_pkg;

  localparam int GROUP_W    = 4;
  localparam int MAX_GROUPS = 16;

  function automatic int nstage_f(input int width, input int stage_groups);
    return width / (GROUP_W * stage_groups);
  endfunction

  function automatic bit params_ok(input int width, input int stage_groups);
    return (width >= 4) && (width <= 64) && (width % GROUP_W == 0) &&
           (stage_groups >= 1) && ((width / GROUP_W) % stage_groups == 0);
  endfunction

  // Carry into group j of a stage, written as a flat sum of products:
  // c_j = G[j-1] | P[j-1]G[j-2] | ... | P[j-1]..P[0]cin.
  // The loops fully unroll for constant j, so no group-to-group ripple remains.
  function automatic logic la_carry(input logic [MAX_GROUPS-1:0] gp,
                                    input logic [MAX_GROUPS-1:0] gg,
                                    input logic                  cin,
                                    input int                    j);
    logic c;
    logic term;
    c = 1'b0;
    for (int i = -1; i < j; i++) begin
      term = (i < 0) ? cin : gg[i];
      for (int k = i + 1; k < j; k++) begin
        term = term & gp[k];
      end
      c = c | term;
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_cla4_group.sv
// Combinational 4-bit carry-lookahead group.
// Ports:
//   a, b  - 4-bit operand slices
//   cin   - carry into bit 0 of the group
//   sum   - 4-bit sum slice
//   gp    - group propagate (all four bits propagate)
//   gg    - group generate (group produces a carry independent of cin)
//   co    - carry out of bit 3
module cla4_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gp,
  output logic       gg,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;

  assign p = a ^ b;
  assign g = a & b;

  // Every internal carry is a two-level AND-OR of P, G and cin.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
              (p[2] & p[1] & p[0] & cin);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// Stage 0 registers the (possibly inverted) operands; each following stage
// resolves STAGE_GROUPS 4-bit groups and registers its sum bits, carry and the
// still-unused upper operand bits. Results appear NSTAGE+1 cycles after input.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid / in_ready  - input handshake (in_ready = no output stall)
//   a, b, cin, sub       - operands, carry/borrow-in, 0:add 1:subtract
//   out_valid / out_ready- output handshake
//   sum, cout, ovf, zero - registered result and flags
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int STAGE_GROUPS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = nstage_f(WIDTH, STAGE_GROUPS);
  localparam int SL     = GROUP_W * STAGE_GROUPS;  // bits resolved per stage

  if (!params_ok(WIDTH, STAGE_GROUPS)) begin : g_param_check
    $error("cla_pipe_adder: illegal WIDTH=%0d / STAGE_GROUPS=%0d", WIDTH, STAGE_GROUPS);
  end

  // The whole pipeline freezes while a finished result waits downstream.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  genvar gi, gj;

  // Register stages 0..NSTAGE-1. x_reg holds resolved sum bits below LO and
  // operand A above; y_reg holds only the not-yet-consumed upper bits of b_eff.
  for (gi = 0; gi < NSTAGE; gi++) begin : g_st
    localparam int LO  = gi * SL;
    localparam int REM = WIDTH - LO;

    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] x_next;
    logic [REM-1:0]   y_reg;
    logic [REM-1:0]   y_next;
    logic             c_reg;
    logic             c_next;
    logic             v_reg;
    logic             v_next;

    if (gi == 0) begin : g_src
      assign x_next = a;
      assign y_next = sub ? ~b : b;
      assign c_next = sub ? ~cin : cin;
      assign v_next = in_valid;
    end else begin : g_src
      always_comb begin
        x_next             = g_st[gi-1].x_reg;
        x_next[LO-1 -: SL] = g_cmp[gi].s_v;
      end
      assign y_next = g_st[gi-1].y_reg[REM+SL-1:SL];
      assign c_next = g_cmp[gi].c_out;
      assign v_next = g_st[gi-1].v_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_reg <= 1'b0;
        x_reg <= '0;
        y_reg <= '0;
        c_reg <= 1'b0;
      end else if (!stall) begin
        v_reg <= v_next;
        // Data only moves with a valid token, so bubbles leave it untouched.
        if (v_next) begin
          x_reg <= x_next;
          y_reg <= y_next;
          c_reg <= c_next;
        end
      end
    end
  end

  // Carry-resolution logic for stage gi, fed from register stage gi-1.
  for (gi = 1; gi <= NSTAGE; gi++) begin : g_cmp
    localparam int LO = (gi - 1) * SL;

    logic [SL-1:0]           a_v;
    logic [SL-1:0]           b_v;
    logic [SL-1:0]           s_v;
    logic [STAGE_GROUPS-1:0] gp_v;
    logic [STAGE_GROUPS-1:0] gg_v;
    logic [STAGE_GROUPS-1:0] co_v;
    logic [STAGE_GROUPS-1:0] co_unused;
    logic [STAGE_GROUPS:0]   c_v;
    logic [MAX_GROUPS-1:0]   gp_ext;
    logic [MAX_GROUPS-1:0]   gg_ext;
    logic                    c_out;

    assign a_v = g_st[gi-1].x_reg[LO +: SL];
    assign b_v = g_st[gi-1].y_reg[SL-1:0];

    for (gj = 0; gj < STAGE_GROUPS; gj++) begin : g_grp
      cla4_group u_grp (
        .a   (a_v[gj*GROUP_W +: GROUP_W]),
        .b   (b_v[gj*GROUP_W +: GROUP_W]),
        .cin (c_v[gj]),
        .sum (s_v[gj*GROUP_W +: GROUP_W]),
        .gp  (gp_v[gj]),
        .gg  (gg_v[gj]),
        .co  (co_v[gj])
      );
    end

    // Group carries come from the stage lookahead over gp/gg, never from the
    // neighbouring group's co, so the ripple depth stays within one group.
    always_comb begin
      gp_ext                   = '0;
      gg_ext                   = '0;
      gp_ext[STAGE_GROUPS-1:0] = gp_v;
      gg_ext[STAGE_GROUPS-1:0] = gg_v;
      c_v[0]                   = g_st[gi-1].c_reg;
      for (int j = 1; j <= STAGE_GROUPS; j++) begin
        c_v[j] = la_carry(gp_ext, gg_ext, g_st[gi-1].c_reg, j);
      end
    end

    assign co_unused = co_v;
    assign c_out     = c_v[STAGE_GROUPS];
  end

  // Final stage: top slice of the sum plus all flags, registered together.
  logic [WIDTH-1:0] sum_next;
  logic [SL-1:0]    top_a;
  logic [SL-1:0]    top_b;
  logic [SL-1:0]    top_s;
  logic             cout_next;
  logic             ovf_next;
  logic             v_last;

  assign top_a = g_cmp[NSTAGE].a_v;
  assign top_b = g_cmp[NSTAGE].b_v;
  assign top_s = g_cmp[NSTAGE].s_v;

  always_comb begin
    sum_next                = g_st[NSTAGE-1].x_reg;
    sum_next[WIDTH-1 -: SL] = top_s;
  end

  assign cout_next = g_cmp[NSTAGE].c_out;
  // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ c_in.
  assign ovf_next  = (top_s[SL-1] ^ top_a[SL-1] ^ top_b[SL-1]) ^ cout_next;
  assign v_last    = g_st[NSTAGE-1].v_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      out_valid <= v_last;
      if (v_last) begin
        sum  <= sum_next;
        cout <= cout_next;
        ovf  <= ovf_next;
        zero <= (sum_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, STAGE_GROUPS=2, latency 3).
// Directed vectors with hand-computed results, then backpressure streaming
// and an asynchronous reset with operations in flight.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .STAGE_GROUPS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
    logic        e_zero;
  } vec_t;

  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Send one operation with out_ready high and check latency and result.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, 32'(lat), 32'd3);
    chk({v.name, " result"}, {13'd0, sum, cout, ovf, zero},
        {13'd0, v.e_sum, v.e_cout, v.e_ovf, v.e_zero});
    $display("vec %-12s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
             v.name, v.a, v.b, v.cin, v.sub, sum, cout, ovf, zero, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tx;
    int rx;
    int stalls;
    int extra;
    vec_t post;

    //                name            a         b         cin   sub   sum       cout  ovf   zero
    vecs[0]  = '{"stage_carry",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"full_wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{"add_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"sub_neg1",     16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"sub_5_3",      16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"sub_5_3_brw",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"sub_ovf",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{"add_cin",      16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"alt_wrap",     16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{"sub_equal",    16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{"neg_ovf",      16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{"all_ones",     16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Reset state and idle behaviour.
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle out_valid", 32'(out_valid), 32'd0);
    end
    $display("reset/idle done");

    // Directed single-operation vectors.
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: five back-to-back ops, out_ready low on cycles 4..6.
    tx = 0; rx = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (out_valid) begin
        chk($sformatf("bp result %0d", rx), 32'(sum), 32'(16'h1000 + 16'(2 * rx)));
        if (out_ready) begin
          $display("bp out %0d: sum=%h cycle=%0d", rx, sum, cyc);
          rx++;
        end else begin
          stalls++;
          chk("bp in_ready during stall", 32'(in_ready), 32'd0);
        end
      end
      if (tx < 5) begin
        in_valid = 1'b1; a = 16'h1000 + 16'(tx); b = 16'(tx); cin = 1'b0; sub = 1'b0;
        if (in_ready) tx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp results received", 32'(rx), 32'd5);
    chk("bp stall cycles", 32'(stalls), 32'd3);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("bp no extra results", 32'(extra), 32'd0);

    // Reset with operations in flight.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0011;
    @(negedge clk);
    a = 16'h0012;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midflight out_valid before rst", 32'(out_valid), 32'd1);
    chk("midflight first sum", 32'(sum), 32'h0030);
    #2;
    rst = 1'b1;
    #1;
    chk("midflight async out_valid", 32'(out_valid), 32'd0);
    chk("midflight async sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midflight no stale result", 32'(extra), 32'd0);
    chk("midflight in_ready after release", 32'(in_ready), 32'd1);
    $display("midflight reset done");

    post = '{"post_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    run_vec(post);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
